// File: rtl/reg_file_bist.sv
// Built-in self test for a 4 x 16-bit register file: writes two complementary
// patterns, reads each back, and reports pass or the first failing register.
module reg_file_bist #(
  parameter logic [15:0] PAT_A = 16'hAAAA,
  parameter logic [15:0] PAT_B = 16'h5555
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [1:0]  RR1,
  output logic [1:0]  RR2,
  output logic [1:0]  WR,
  output logic [15:0] WD,
  output logic        RegWrite,
  input  logic [15:0] RD1,
  input  logic [15:0] RD2,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [1:0]  fail_reg
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t      state;
  logic [1:0]  idx;
  logic        pat;
  logic [15:0] pat_val;
  logic [15:0] exp_val;

  // r0 is write-protected, so it must always read back as zero
  always_comb begin
    pat_val = pat ? PAT_B : PAT_A;
    exp_val = (idx == 2'd0) ? '0 : (pat_val ^ {14'b0, idx});
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      pat      <= 1'b0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      fail_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= WRITE;
            idx      <= '0;
            pat      <= 1'b0;
            pass     <= 1'b0;
            fail     <= 1'b0;
            fail_reg <= '0;
          end
        end
        WRITE: begin
          idx <= idx + 2'd1;
          if (idx == 2'd3) state <= READ;
        end
        READ: begin
          if (RD1 != exp_val || RD2 != '0) begin
            fail     <= 1'b1;
            fail_reg <= idx;
            pass     <= 1'b0;
            state    <= DONE;
          end else begin
            // idx wraps 3 -> 0, so the next phase starts at register 0
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
              if (pat) begin
                pass  <= 1'b1;
                state <= DONE;
              end else begin
                pat   <= 1'b1;
                state <= WRITE;
              end
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decode: outputs settle after the posedge, ahead of the negedge write
  always_comb begin
    RR1      = '0;
    RR2      = '0;
    WR       = '0;
    WD       = '0;
    RegWrite = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      WRITE: begin
        RegWrite = 1'b1;
        WR       = idx;
        WD       = pat_val ^ {14'b0, idx};
        busy     = 1'b1;
      end
      READ: begin
        RR1  = idx;
        busy = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reg_file_bist.sv
// Directed bench for reg_file_bist with a behavioural register file that can
// model a writable r0 or a WR[1] stuck-at-0 fault.
module tb_reg_file_bist;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  RR1, RR2, WR;
  logic [15:0] WD;
  logic        RegWrite;
  logic [15:0] RD1, RD2;
  logic        busy, done, pass, fail;
  logic [1:0]  fail_reg;

  reg_file_bist #(
    .PAT_A(16'hAAAA),
    .PAT_B(16'h5555)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .RR1(RR1), .RR2(RR2), .WR(WR), .WD(WD), .RegWrite(RegWrite),
    .RD1(RD1), .RD2(RD2),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .fail_reg(fail_reg)
  );

  always #5 clock = ~clock;

  // register file model: negedge write, combinational read, r0 protected
  logic [15:0] rf [4];
  logic        rf_clr;
  logic        fault_r0;
  logic        fault_wr1;
  logic [1:0]  wa;
  int unsigned nwrites = 0;

  assign wa  = fault_wr1 ? {1'b0, WR[0]} : WR;
  assign RD1 = rf[RR1];
  assign RD2 = rf[RR2];

  always @(negedge clock) begin
    if (rf_clr) begin
      for (int i = 0; i < 4; i++) rf[i] <= '0;
    end else if (RegWrite) begin
      if (wa != 2'd0 || fault_r0) rf[wa] <= WD;
      nwrites <= nwrites + 1;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_rf;
    rf_clr = 1'b1;
    tick();
    rf_clr = 1'b0;
  endtask

  // leaves the bench 1 time unit after edge E0
  task automatic launch;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int unsigned nw;
    int last;
    int npulses;

    reset = 1'b1; start = 1'b0; rf_clr = 1'b1; fault_r0 = 1'b0; fault_wr1 = 1'b0;
    tick(); tick();
    #2 reset = 1'b0;
    rf_clr = 1'b0;
    tick();
    check("rst_ctrl", {busy, done, pass, fail, fail_reg, RegWrite, WR, RR1, RR2}, '0);
    check("rst_wd", WD, 16'h0000);

    // good register file, single start pulse
    launch();
    check("e0_busy", busy, 1);
    check("e0_wr", {RegWrite, WR, RR1, RR2}, {1'b1, 2'd0, 2'd0, 2'd0});
    check("e0_wd", WD, 16'hAAAA);
    tick();
    check("e1_wr", {RegWrite, WR}, {1'b1, 2'd1});
    check("e1_wd", WD, 16'hAAAB);
    repeat (3) tick();
    check("e4_read", {RegWrite, WR, RR1, RR2, busy}, {1'b0, 2'd0, 2'd0, 2'd0, 1'b1});
    check("e4_wd", WD, 16'h0000);
    repeat (11) tick();
    check("e15_state", {busy, done}, 2'b10);
    tick();
    check("e16_done", {busy, done, pass, fail}, 4'b0110);
    tick();
    check("e17_hold", {busy, done, pass, fail}, 4'b0010);
    check("rf0", rf[0], 16'h0000);
    check("rf1", rf[1], 16'h5554);
    check("rf2", rf[2], 16'h5557);
    check("rf3", rf[3], 16'h5556);

    // start re-pulsed at E3 and E10 has no effect
    launch();
    for (int e = 1; e <= 16; e++) begin
      start = (e == 3 || e == 10);
      tick();
    end
    start = 1'b0;
    check("repulse_done", {busy, done, pass, fail}, 4'b0110);
    tick(); tick();
    check("repulse_idle", {busy, done}, 2'b00);

    // r0 writable: miscompare on register 0 at E5
    fault_r0 = 1'b1;
    clear_rf();
    launch();
    check("r0f_e0_clr", {pass, fail}, 2'b00);
    repeat (4) tick();
    check("r0f_e4", {busy, done}, 2'b10);
    tick();
    check("r0f_e5", {done, pass, fail, fail_reg}, {1'b1, 1'b0, 1'b1, 2'd0});
    tick();
    check("r0f_e6", {busy, done, fail}, 3'b001);
    fault_r0 = 1'b0;

    // WR[1] stuck at 0: r1 overwritten by the idx 3 write
    fault_wr1 = 1'b1;
    clear_rf();
    launch();
    repeat (5) tick();
    check("wr1_e5", {busy, done, fail}, 3'b100);
    tick();
    check("wr1_e6", {done, pass, fail, fail_reg}, {1'b1, 1'b0, 1'b1, 2'd1});
    check("wr1_r1", rf[1], 16'hAAA9);
    fault_wr1 = 1'b0;
    tick();

    // reset asserted between edges during WRITE
    launch();
    tick();
    #1 reset = 1'b1;
    #1;
    check("rst_mid", {RegWrite, busy, pass, fail, done}, '0);
    nw = nwrites;
    #3 reset = 1'b0;
    repeat (5) tick();
    check("rst_nowr", nwrites, nw);
    check("rst_idle", {busy, RegWrite}, 2'b00);

    // start held high: back-to-back runs every 18 cycles
    clear_rf();
    start   = 1'b1;
    last    = 0;
    npulses = 0;
    for (int c = 0; c < 80; c++) begin
      tick();
      if (done) begin
        if (npulses > 0) check("held_period", c - last, 18);
        check("held_pass", {pass, fail}, 2'b10);
        last = c;
        npulses++;
      end
    end
    start = 1'b0;
    check("held_pulses", npulses, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_file_bist.md
REG_FILE_BIST -- requirements
Module: reg_file_bist

Interface
REQ-001 Parameter PAT_A, default 16'hAAAA: first test pattern.
REQ-002 Parameter PAT_B, default 16'h5555: second test pattern.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 Port `clock`, input, 1 bit: single clock; all state updates on posedge.
REQ-005 Port `reset`, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port `start`, input, 1 bit: begins a test run; sampled only in IDLE.
REQ-007 Port `RR1`, output, 2 bits: register file read address 1.
REQ-008 Port `RR2`, output, 2 bits: register file read address 2.
REQ-009 Port `WR`, output, 2 bits: register file write address.
REQ-010 Port `WD`, output, 16 bits: register file write data.
REQ-011 Port `RegWrite`, output, 1 bit: register file write enable.
REQ-012 Port `RD1`, input, 16 bits: register file read data 1.
REQ-013 Port `RD2`, input, 16 bits: register file read data 2.
REQ-014 Port `busy`, output, 1 bit: high in WRITE and READ.
REQ-015 Port `done`, output, 1 bit: high for exactly one cycle, in DONE.
REQ-016 Port `pass`, output, 1 bit: test passed; held until the next accepted start.
REQ-017 Port `fail`, output, 1 bit: test failed; held until the next accepted start.
REQ-018 Port `fail_reg`, output, 2 bits: index of the first miscompare; held until the next accepted start.

Function
REQ-019 States SHALL be IDLE, WRITE, READ and DONE, with a 2-bit index `idx` and a 1-bit pattern select `pat` (0 selects PAT_A, 1 selects PAT_B).
REQ-020 Register file outputs SHALL be Moore-decoded from state, idx and pat, changing only after a posedge, so that the register file's negedge write sees stable values.
REQ-021 Expected value: exp(idx) SHALL be PAT ^ {14'b0, idx} for idx 1..3, and 16'h0000 for idx 0.
REQ-022 IDLE: on a posedge with start=1 the block SHALL go to WRITE with idx=0 and pat=0, and clear pass, fail and fail_reg.
REQ-023 WRITE: RegWrite=1, WR=idx, WD=PAT^{14'b0,idx} (idx 0 included, to test write protection), RR1=RR2=0; idx increments each posedge.
REQ-024 WRITE exit: at idx=3 the next state SHALL be READ with idx=0.
REQ-025 READ: RegWrite=0, WR=0, WD=0, RR1=idx, RR2=2'b00.
REQ-026 READ compare: at each posedge the block SHALL compare RD1 against exp(idx) and RD2 against 16'h0000.
REQ-027 READ mismatch: on any mismatch the block SHALL set fail=1, fail_reg=idx, pass=0 and go to DONE (abort).
REQ-028 READ exit, pattern A: at idx=3 with no mismatch and pat=0, the block SHALL set pat=1 and go to WRITE with idx=0.
REQ-029 READ exit, pattern B: at idx=3 with no mismatch and pat=1, the block SHALL set pass=1 and go to DONE.
REQ-030 DONE SHALL last one cycle and then return to IDLE.
REQ-031 Latency: start sampled at edge E0; writes in cycles E0..E3; compares at E5..E8 (A) and E13..E16 (B); done high in cycle E16..E17; a full pass is 17 cycles.
REQ-032 start SHALL be ignored in WRITE, READ and DONE; start held high SHALL re-launch a run from IDLE.
REQ-033 In IDLE and DONE, all register file outputs SHALL be 0.

Reset
REQ-034 Reset assertion SHALL immediately force state=IDLE, idx=0, pat=0, pass=0, fail=0, fail_reg=0, and RegWrite/WR/WD/RR1/RR2/busy/done=0, independent of clock.
REQ-035 Reset mid-run SHALL abort the run with no further register file writes; the next run after release SHALL begin only on a new start.

Verification
REQ-036 Scenario, good register file: start pulse at E0 -> busy E0..E16, done one cycle after E16, pass=1, fail=0; final regs r1=5554, r2=5557, r3=5556, r0=0000.
REQ-037 Scenario, r0 writable (fault model): start -> miscompare at E5, fail=1, fail_reg=00, done one cycle later, pass=0.
REQ-038 Scenario, WR[1] stuck-at-0 (fault model): start -> r1 reads AAA9 instead of AAAB at E6 -> fail=1, fail_reg=01.
REQ-039 Scenario, start re-pulsed at E3 and E10 -> ignored; run completes at the same cycles with pass=1.
REQ-040 Scenario, reset asserted mid-WRITE (between edges) -> RegWrite, busy, pass and fail all 0 immediately; no writes until the next start.
REQ-041 Scenario, start held high continuously -> back-to-back runs, each with a one-cycle done pulse every 18 cycles, pass=1 each run.
